// File: rtl/iop_bus_pkg.sv
// Shared definitions for the R408 IOP data bus: arbiter states, default widths
// and the read data returned when a grant is abandoned.
package iop_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DBUS_AW = 24;
  localparam int DBUS_DW = 8;

  localparam logic [7:0] DBUS_ERR_DATA = 8'hFF;

endpackage

// File: rtl/dbus_arb_tmo.sv
// Grant watchdog for dbus_arb2: down-counter loaded while clr is high, counting
// while en is high; expired flags the TIMEOUT-th enabled cycle since the last clr.
module dbus_arb_tmo #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  // Loading TIMEOUT-1 makes the terminal count land on the TIMEOUT-th grant cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= CW'(TIMEOUT - 1);
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign expired = en && (r_cnt == '0);

endmodule

// File: rtl/dbus_arb2.sv
// Round-robin two-master arbiter for the R408 IOP data bus.
// Define DBUS_ARB_TIMEOUT_EN to abandon grants that wait TIMEOUT cycles for ready.
//
//   state | meaning
//   IDLE  | no grant; arbitrate between pending requests
//   GNT0  | slave port mirrors master 0 until its read/write completes
//   GNT1  | slave port mirrors master 1 until its read/write completes
module dbus_arb2
  import iop_bus_pkg::*;
#(
  parameter int AW      = DBUS_AW,
  parameter int DW      = DBUS_DW,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_raddr,
  input  logic [AW-1:0] m1_raddr,
  input  logic [AW-1:0] m0_waddr,
  input  logic [AW-1:0] m1_waddr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m0_read,
  input  logic          m1_read,
  input  logic          m0_write,
  input  logic          m1_write,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m0_rrdy,
  output logic          m1_rrdy,
  output logic          m0_wrdy,
  output logic          m1_wrdy,
  output logic [AW-1:0] s_raddr,
  output logic [AW-1:0] s_waddr,
  output logic [DW-1:0] s_wdata,
  output logic          s_read,
  output logic          s_write,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rrdy,
  input  logic          s_wrdy,
  output logic          err,
  output logic          err_id
);

  arb_state_t    r_state;
  logic          r_last;
  logic          r_rdone;
  logic          r_wdone;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_req0;
  logic          w_req1;
  logic          w_req_r;
  logic          w_req_w;
  logic          w_r_pend;
  logic          w_w_pend;
  logic          w_done;
  logic          w_tmo;
  logic          w_tmo_hit;
  logic          w_rrdy;
  logic          w_wrdy;
  logic [DW-1:0] w_rdata;

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);
  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  always_comb begin
    w_req_r = 1'b0;
    w_req_w = 1'b0;
    s_raddr = '0;
    s_waddr = '0;
    s_wdata = '0;
    case (r_state)
      GNT0: begin
        w_req_r = m0_read;
        w_req_w = m0_write;
        s_raddr = m0_raddr;
        s_waddr = m0_waddr;
        s_wdata = m0_wdata;
      end
      GNT1: begin
        w_req_r = m1_read;
        w_req_w = m1_write;
        s_raddr = m1_raddr;
        s_waddr = m1_waddr;
        s_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  // A direction that already saw its ready stops driving the slave.
  assign w_r_pend = w_req_r & ~r_rdone;
  assign w_w_pend = w_req_w & ~r_wdone;
  assign s_read   = w_r_pend;
  assign s_write  = w_w_pend;

  assign w_done    = (w_gnt0 | w_gnt1)
                   & (~w_req_r | r_rdone | s_rrdy)
                   & (~w_req_w | r_wdone | s_wrdy);
  assign w_tmo_hit = w_tmo & ~w_done;

  assign w_rrdy  = w_r_pend & (s_rrdy | w_tmo_hit);
  assign w_wrdy  = w_w_pend & (s_wrdy | w_tmo_hit);
  assign w_rdata = (w_r_pend & s_rrdy)    ? s_rdata :
                   (w_r_pend & w_tmo_hit) ? DW'(DBUS_ERR_DATA) : '0;

  assign m0_rrdy  = w_gnt0 & w_rrdy;
  assign m0_wrdy  = w_gnt0 & w_wrdy;
  assign m0_rdata = w_gnt0 ? w_rdata : '0;
  assign m1_rrdy  = w_gnt1 & w_rrdy;
  assign m1_wrdy  = w_gnt1 & w_wrdy;
  assign m1_rdata = w_gnt1 ? w_rdata : '0;

  assign err    = w_tmo_hit;
  assign err_id = w_tmo_hit & w_gnt1;

`ifdef DBUS_ARB_TIMEOUT_EN
  dbus_arb_tmo #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (r_state == IDLE),
    .en      (w_gnt0 | w_gnt1),
    .expired (w_tmo)
  );
`else
  logic w_unused_tmo;
  assign w_tmo        = 1'b0;
  assign w_unused_tmo = (TIMEOUT == 0);
`endif

  // r_last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_rdone <= 1'b0;
      r_wdone <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rdone <= 1'b0;
          r_wdone <= 1'b0;
          if (w_req0 && (!w_req1 || r_last)) begin
            r_state <= GNT0;
          end else if (w_req1) begin
            r_state <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (w_done || w_tmo_hit) begin
            r_state <= IDLE;
            r_last  <= w_gnt1;
            r_rdone <= 1'b0;
            r_wdone <= 1'b0;
          end else begin
            r_rdone <= r_rdone | (w_req_r & s_rrdy);
            r_wdone <= r_wdone | (w_req_w & s_wrdy);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_arb2.sv
// Directed self-checking bench for dbus_arb2 (TIMEOUT=4; timeout step active
// only when DBUS_ARB_TIMEOUT_EN is defined).
module tb_dbus_arb2;

  localparam int AW = 24;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_raddr, m1_raddr, m0_waddr, m1_waddr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_read, m1_read, m0_write, m1_write;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_rrdy, m1_rrdy, m0_wrdy, m1_wrdy;
  logic [AW-1:0] s_raddr, s_waddr;
  logic [DW-1:0] s_wdata;
  logic          s_read, s_write;
  logic [DW-1:0] s_rdata;
  logic          s_rrdy, s_wrdy;
  logic          err, err_id;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dbus_arb2 #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_raddr(m0_raddr), .m1_raddr(m1_raddr),
    .m0_waddr(m0_waddr), .m1_waddr(m1_waddr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_read(m0_read), .m1_read(m1_read),
    .m0_write(m0_write), .m1_write(m1_write),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rrdy(m0_rrdy), .m1_rrdy(m1_rrdy),
    .m0_wrdy(m0_wrdy), .m1_wrdy(m1_wrdy),
    .s_raddr(s_raddr), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .s_read(s_read), .s_write(s_write),
    .s_rdata(s_rdata), .s_rrdy(s_rrdy), .s_wrdy(s_wrdy),
    .err(err), .err_id(err_id)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Next cycle: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [127:0] all_out();
    return {s_read, s_write, s_raddr, s_waddr, s_wdata, m0_rrdy, m0_wrdy,
            m1_rrdy, m1_wrdy, m0_rdata, m1_rdata, err, err_id};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_last;
    logic exp_g;

    rst = 1'b0;
    m0_raddr = '0; m1_raddr = '0; m0_waddr = '0; m1_waddr = '0;
    m0_wdata = '0; m1_wdata = '0;
    m0_read = 0; m1_read = 0; m0_write = 0; m1_write = 0;
    s_rdata = '0; s_rrdy = 0; s_wrdy = 0;

    // Reset held with a request pending: nothing may be granted.
    tick();
    m0_read = 1;
    tick();
    settle();
    chk("reset_outputs", all_out(), '0);
    m0_read = 0;
    rst = 1'b1;
    tick();

    // Single read by m0, ready on the third grant cycle.
    m0_read = 1; m0_raddr = 24'h000100;
    settle();
    chk("rd_c0_idle", s_read, 1'b0);
    tick(); settle();
    chk("rd_c1_sread", s_read, 1'b1);
    chk("rd_c1_raddr", s_raddr, 24'h000100);
    chk("rd_c1_rrdy", m0_rrdy, 1'b0);
    tick(); settle();
    chk("rd_c2_sread", s_read, 1'b1);
    tick();
    s_rrdy = 1; s_rdata = 8'h5A;
    settle();
    chk("rd_c3_sread", s_read, 1'b1);
    chk("rd_c3_m0rrdy", m0_rrdy, 1'b1);
    chk("rd_c3_m0rdata", m0_rdata, 8'h5A);
    chk("rd_c3_m1rrdy", m1_rrdy, 1'b0);
    chk("rd_c3_m1rdata", m1_rdata, 8'h00);
    tick();
    m0_read = 0; s_rrdy = 0; s_rdata = '0;
    settle();
    chk("rd_c4_idle", {s_read, m0_rrdy}, 2'b00);

    // Simultaneous writes right after reset: m0 first, then m1.
    rst = 0; tick(); rst = 1;
    m0_write = 1; m0_waddr = 24'h0000A0; m0_wdata = 8'h11;
    m1_write = 1; m1_waddr = 24'h0000B0; m1_wdata = 8'h22;
    s_wrdy = 1;
    settle();
    chk("wr_c0_swrite", s_write, 1'b0);
    chk("wr_c0_wrdy", {m0_wrdy, m1_wrdy}, 2'b00);
    tick(); settle();
    chk("wr_c1_swrite", s_write, 1'b1);
    chk("wr_c1_waddr", s_waddr, 24'h0000A0);
    chk("wr_c1_wdata", s_wdata, 8'h11);
    chk("wr_c1_wrdy", {m0_wrdy, m1_wrdy}, 2'b10);
    tick();
    m0_write = 0;
    settle();
    chk("wr_c2_idle", {s_write, m0_wrdy, m1_wrdy}, 3'b000);
    tick(); settle();
    chk("wr_c3_waddr", s_waddr, 24'h0000B0);
    chk("wr_c3_wdata", s_wdata, 8'h22);
    chk("wr_c3_wrdy", {m0_wrdy, m1_wrdy}, 2'b01);
    tick();
    m1_write = 0; s_wrdy = 0;
    settle();
    chk("wr_c4_idle", {s_write, m0_wrdy, m1_wrdy}, 3'b000);

    // m0 read+write: write ready first, grant held until read ready.
    tick();
    m0_read = 1; m0_write = 1; m0_raddr = 24'h000300; m0_waddr = 24'h000400;
    m0_wdata = 8'h33;
    tick();
    s_wrdy = 1;
    settle();
    chk("rw_c1_req", {s_read, s_write}, 2'b11);
    chk("rw_c1_rdy", {m0_rrdy, m0_wrdy}, 2'b01);
    tick();
    s_wrdy = 0;
    settle();
    chk("rw_c2_req", {s_read, s_write}, 2'b10);
    chk("rw_c2_rdy", {m0_rrdy, m0_wrdy}, 2'b00);
    tick();
    s_rrdy = 1; s_rdata = 8'hC3;
    settle();
    chk("rw_c3_req", {s_read, s_write}, 2'b10);
    chk("rw_c3_rdy", {m0_rrdy, m0_wrdy}, 2'b10);
    chk("rw_c3_rdata", m0_rdata, 8'hC3);
    tick();
    m0_read = 0; m0_write = 0; s_rrdy = 0; s_rdata = '0;
    settle();
    chk("rw_c4_idle", {s_read, s_write, m0_rrdy, m0_wrdy}, 4'b0000);

    // Both masters read continuously; slave always ready.
    tick();
    m0_read = 1; m0_raddr = 24'hAAAA00;
    m1_read = 1; m1_raddr = 24'hBBBB00;
    s_rrdy = 1; s_rdata = 8'h42;
    exp_last = 1'b0;  // the read+write above was m0's
    for (int i = 0; i < 20; i++) begin
      exp_g = ~exp_last;
      exp_last = exp_g;
      tick(); settle();
      chk($sformatf("rr_%0d_rrdy", i), {m0_rrdy, m1_rrdy}, exp_g ? 2'b01 : 2'b10);
      chk($sformatf("rr_%0d_raddr", i), s_raddr, exp_g ? 24'hBBBB00 : 24'hAAAA00);
      tick(); settle();
      chk($sformatf("rr_%0d_idle", i), {s_read, m0_rrdy, m1_rrdy}, 3'b000);
    end
    m0_read = 0; m1_read = 0; s_rrdy = 0; s_rdata = '0;

    // Reset while GNT1 waits, then a tie must go to m0.
    tick();
    m1_read = 1; m1_raddr = 24'h111111; m0_raddr = 24'h222222;
    tick(); settle();
    chk("rst_gnt1_raddr", s_raddr, 24'h111111);
    chk("rst_gnt1_wait", {s_read, m1_rrdy}, 2'b10);
    rst = 0; m0_read = 1;
    tick();
    rst = 1;
    settle();
    chk("rst_mid_outputs", all_out(), '0);
    tick();
    s_rrdy = 1; s_rdata = 8'h77;
    settle();
    chk("rst_tie_raddr", s_raddr, 24'h222222);
    chk("rst_tie_rrdy", {m0_rrdy, m1_rrdy}, 2'b10);
    chk("rst_tie_rdata", m0_rdata, 8'h77);
    tick();
    m0_read = 0; s_rrdy = 0; s_rdata = '0;
    // m1 still requesting; it gets the next grant and is completed here.
    tick();
    s_rrdy = 1;
    settle();
    chk("rst_m1_after", {m0_rrdy, m1_rrdy}, 2'b01);
    tick();
    m1_read = 0; s_rrdy = 0;

    // m1 read with a slave that never answers.
    tick();
    m1_read = 1; m1_raddr = 24'h000999;
    for (int c = 1; c <= 3; c++) begin
      tick(); settle();
      chk($sformatf("tmo_c%0d", c), {s_read, m1_rrdy, err}, 3'b100);
    end
    tick(); settle();
`ifdef DBUS_ARB_TIMEOUT_EN
    chk("tmo_c4_rrdy", m1_rrdy, 1'b1);
    chk("tmo_c4_rdata", m1_rdata, 8'hFF);
    chk("tmo_c4_err", {err, err_id}, 2'b11);
    tick();
    m1_read = 0;
    settle();
    chk("tmo_c5_idle", {s_read, m1_rrdy, err}, 3'b000);
`else
    chk("notmo_c4", {s_read, m1_rrdy, m1_rdata, err, err_id}, {2'b10, 8'h00, 2'b00});
    tick(); tick(); settle();
    chk("notmo_c6", {s_read, m1_rrdy, err}, 3'b100);
    s_rrdy = 1; s_rdata = 8'h19;
    settle();
    chk("notmo_done", {m1_rrdy, m1_rdata}, {1'b1, 8'h19});
    tick();
    m1_read = 0; s_rrdy = 0;
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
